// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;

  localparam int INST_W = 32;
  localparam int ADDR_W = 64;
  localparam logic [ADDR_W-1:0] PC_INC = 64'd4;

  typedef enum logic [1:0] {
    FETCH,
    MISS,
    KILL
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - fetch-to-L1 I-cache request/response bundle
interface if_fetch_unit_if;
  import if_pkg::*;

  logic [ADDR_W-1:0] addr_C_L1;
  logic              read_C_L1;
  logic              write_C_L1;
  logic              stall;
  logic [INST_W-1:0] read_data_L1_C;

  modport master (
    output addr_C_L1,
    output read_C_L1,
    output write_C_L1,
    input  stall,
    input  read_data_L1_C
  );

  modport slave (
    input  addr_C_L1,
    input  read_C_L1,
    input  write_C_L1,
    output stall,
    output read_data_L1_C
  );

endinterface

// File: rtl/if_fetch_fifo.sv
// rtl/if_fetch_fifo.sv - instruction buffer with registered head and synchronous clear
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  localparam int AW = $clog2(FIFO_DEPTH)
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(FIFO_DEPTH);

  fetch_entry_t r_mem [FIFO_DEPTH];
  fetch_entry_t r_head;
  fetch_entry_t w_next_head;
  logic [AW-1:0] r_rd, r_wr, w_next_rd;
  logic [AW:0]   r_count, w_next_count;
  logic          w_push, w_pop;

  assign full  = (r_count == LP_DEPTH);
  assign empty = (r_count == '0);
  assign count = r_count;
  assign dout  = r_head;

  assign w_pop        = pop & ~empty;
  assign w_push       = push & (~full | w_pop);
  assign w_next_rd    = w_pop ? r_rd + 1'b1 : r_rd;
  assign w_next_count = r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

  // The new head is the word being written when it lands straight at the read slot.
  always_comb begin
    w_next_head = r_mem[w_next_rd];
    if (w_push && (r_wr == w_next_rd)) begin
      w_next_head = din;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !clear) begin
      r_mem[r_wr] <= din;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else if (clear) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_head  <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      r_rd    <= w_next_rd;
      r_count <= w_next_count;
      if (w_next_count != '0) begin
        r_head <= w_next_head;
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - PC owner and L1 I-side requester; FETCH_PERF_CNT_EN adds fetch/miss counters
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  if_fetch_unit_if.master       l1,
  input  logic                  redirect_valid,
  input  logic [ADDR_W-1:0]     redirect_pc,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_W-1:0]     inst_data,
  output logic [ADDR_W-1:0]     inst_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_miss_cnt
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] LP_DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] LP_RESET_PC = RESET_PC & ~64'h3;

  fetch_state_t      r_state, w_state_n;
  logic [ADDR_W-1:0] r_pc, w_pc_n;
  logic [ADDR_W-1:0] r_pending, w_pending_n;
  logic              r_started;
  logic              w_read, w_accept, w_push, w_pop;
  logic              w_full, w_empty;
  logic [AW:0]       w_count;
  logic [ADDR_W-1:0] w_target;
  fetch_entry_t      w_din, w_head;

  assign w_target = redirect_pc & ~64'h3;
  assign w_accept = w_read & ~l1.stall;
  assign w_pop    = inst_ready & ~w_empty & ~redirect_valid;
  assign w_push   = w_accept & ~redirect_valid & (r_state != KILL);
  assign w_din    = '{pc: r_pc, inst: l1.read_data_L1_C};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state   <= FETCH;
      r_pc      <= LP_RESET_PC;
      r_pending <= '0;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_pc      <= w_pc_n;
      r_pending <= w_pending_n;
      r_started <= 1'b1;
    end
  end

  // A request stalled by L1 is never withdrawn; a redirect during it only re-aims the follow-up PC.
  always_comb begin
    w_state_n   = r_state;
    w_pc_n      = r_pc;
    w_pending_n = r_pending;
    w_read      = 1'b0;
    case (r_state)
      FETCH:      w_read = r_started & ((w_count < LP_DEPTH) | (w_full & inst_ready));
      MISS, KILL: w_read = 1'b1;
      default:    w_read = 1'b0;
    endcase
    if (redirect_valid) begin
      if (w_read && l1.stall) begin
        w_pending_n = w_target;
        w_state_n   = KILL;
      end else begin
        w_pc_n    = w_target;
        w_state_n = FETCH;
      end
    end else if (w_read) begin
      if (l1.stall) begin
        if (r_state == FETCH) begin
          w_state_n = MISS;
        end
      end else begin
        w_pc_n    = (r_state == KILL) ? r_pending : r_pc + PC_INC;
        w_state_n = FETCH;
      end
    end
  end

  if_fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (w_push),
    .pop   (w_pop),
    .clear (redirect_valid),
    .din   (w_din),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  assign l1.addr_C_L1  = r_pc;
  assign l1.read_C_L1  = w_read;
  assign l1.write_C_L1 = 1'b0;
  assign inst_valid    = ~w_empty;
  assign inst_data     = w_head.inst;
  assign inst_pc       = w_head.pc;

`ifdef FETCH_PERF_CNT_EN
  logic w_miss_evt;
  assign w_miss_evt = (r_state == FETCH) & w_read & l1.stall;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      perf_fetch_cnt <= '0;
      perf_miss_cnt  <= '0;
    end else begin
      if (w_accept && (perf_fetch_cnt != 32'hFFFF_FFFF)) begin
        perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      end
      if (w_miss_evt && (perf_miss_cnt != 32'hFFFF_FFFF)) begin
        perf_miss_cnt <= perf_miss_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit with a PC-stream reference model
module tb_if_fetch_unit;

  localparam logic [63:0] RST_PC = 64'h1000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic        clk;
  logic        nrst;
  logic        stall_i, ready_i, rv_i;
  logic [63:0] rp_i;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [63:0] inst_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_miss_cnt;
`endif

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(4)) dut (
    .clk            (clk),
    .nrst           (nrst),
    .l1             (bus.master),
    .redirect_valid (rv_i),
    .redirect_pc    (rp_i),
    .inst_valid     (inst_valid),
    .inst_ready     (ready_i),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_miss_cnt  (perf_miss_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2] ^ 32'h5A3C_9E17 ^ a[63:32];
  endfunction

  assign bus.stall          = stall_i;
  assign bus.read_data_L1_C = mem_word(bus.addr_C_L1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  ent_t q[$];
  logic [63:0] m_pc = RST_PC;
  logic [63:0] m_pending = '0;
  bit m_out = 0, m_kill = 0, m_started = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares the visible head against the expected buffer and retires popped entries.
  always @(negedge clk) begin
    if (nrst) begin
      chk("write_zero", 64'(bus.write_C_L1), 64'd0);
      chk("inst_valid", 64'(inst_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
        chk("head_pc", inst_pc, q[0].pc);
        chk("head_data", 64'(inst_data), 64'(q[0].inst));
        if (ready_i && !rv_i) void'(q.pop_front());
      end
    end
  end

  // Reference model: the program-order PC stream with kill/redirect rules, updated just before each edge.
  always @(negedge clk) begin
    logic e_read;
    #3;
    if (!nrst) begin
      q.delete();
      m_pc = RST_PC;
      m_pending = '0;
      m_out = 0;
      m_kill = 0;
      m_started = 0;
    end else begin
      if (bus.read_C_L1 && !bus.stall) acc_cnt++;
      if (!m_started) begin
        chk("read_first", 64'(bus.read_C_L1), 64'd0);
        m_started = 1;
      end else begin
        e_read = m_out || (q.size() < 4);
        chk("read_req", 64'(bus.read_C_L1), 64'(e_read));
        if (e_read) chk("addr", bus.addr_C_L1, m_pc);
        if (rv_i) begin
          q.delete();
          if (e_read && stall_i) begin
            m_kill = 1;
            m_pending = rp_i & ~64'h3;
            m_out = 1;
          end else begin
            m_pc = rp_i & ~64'h3;
            m_kill = 0;
            m_out = 0;
          end
        end else if (e_read) begin
          if (stall_i) begin
            m_out = 1;
          end else begin
            if (m_kill) begin
              m_pc = m_pending;
            end else begin
              q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
              m_pc = m_pc + 64'd4;
            end
            m_kill = 0;
            m_out = 0;
          end
        end
      end
    end
  end

  task automatic step(input logic s, input logic r, input logic v, input logic [63:0] p);
    @(posedge clk);
    #1;
    stall_i = s;
    ready_i = r;
    rv_i    = v;
    rp_i    = p;
  endtask

  task automatic check_reset_values();
    chk("rst_read", 64'(bus.read_C_L1), 64'd0);
    chk("rst_addr", bus.addr_C_L1, RST_PC);
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_pc", inst_pc, 64'd0);
    chk("rst_data", 64'(inst_data), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_perf_fetch", 64'(perf_fetch_cnt), 64'd0);
    chk("rst_perf_miss", 64'(perf_miss_cnt), 64'd0);
`endif
  endtask

  initial begin
    nrst = 1'b0; stall_i = 1'b0; ready_i = 1'b1; rv_i = 1'b0; rp_i = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_values();
    nrst = 1'b1;
    // hits in order
    repeat (6) step(0, 1, 0, 0);
    // long miss
    repeat (5) step(1, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    // drain under a miss, then fill with decode stalled
    repeat (3) step(1, 1, 0, 0);
    step(0, 0, 0, 0);
    acc_cnt = 0;
    repeat (7) step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("fill_count", 64'(acc_cnt), 64'd4);
    acc_cnt = 0;
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("one_more", 64'(acc_cnt), 64'd1);
    // redirect during a miss
    step(1, 1, 0, 0);
    step(1, 1, 1, 64'h2003);
    repeat (2) step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    // two redirects in one miss
    step(1, 1, 0, 0);
    step(1, 1, 1, 64'h3000);
    step(1, 1, 0, 0);
    step(1, 1, 1, 64'h4000);
    step(1, 1, 0, 0);
    repeat (4) step(0, 1, 0, 0);
    // pc wrap
    step(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (5) step(0, 1, 0, 0);
    // async reset mid-miss
    repeat (2) step(1, 1, 0, 0);
    #2 nrst = 1'b0;
    #1 check_reset_values();
    @(posedge clk);
    #1 nrst = 1'b1;
    stall_i = 1'b0;
    repeat (5) step(0, 1, 0, 0);
    // random traffic
    repeat (3000) begin
      logic s, r, v;
      logic [63:0] p;
      s = ($urandom_range(0, 3) == 0);
      r = ($urandom_range(0, 9) < 7);
      v = ($urandom_range(0, 19) == 0);
      p = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) p = 64'hFFFF_FFFF_FFFF_FFF0 | {60'd0, p[3:0]};
      if (v) r = 1'b0;
      step(s, r, v, p);
    end
    repeat (8) step(0, 1, 0, 0);
    @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
